// File: rtl/serial_sub_03.sv
// rtl/serial_sub_03.sv - bit-serial LSB-first subtractor; optional saturation via SERIAL_SUB_03_SAT_EN
module serial_sub_03 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out1,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             diff;
    logic             borrow_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] final_val;
    logic [WIDTH-1:0] result_fin;

    // Per-bit full-subtractor and the assembled result once the last bit lands
    always_comb begin
        diff       = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        last_bit   = (cnt == CW'(WIDTH - 1));
        final_val  = {diff, res_sr[WIDTH-1:1]};
`ifdef SERIAL_SUB_03_SAT_EN
        result_fin = borrow_nxt ? '0 : final_val;
`else
        result_fin = final_val;
`endif
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/result shifting; out1 and borrow_out only update on the final shift
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            out1       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= in1;
                        b_sr   <= in2;
                        res_sr <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= final_val;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        out1       <= result_fin;
                        borrow_out <= borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_03.sv
// tb/tb_serial_sub_03.sv - directed self-checking bench for serial_sub_03 (WIDTH=8)
module tb_serial_sub_03;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [7:0] out1;
    logic       borrow_out;

    int vectors    = 0;
    int miscompares = 0;

    serial_sub_03 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in1        (in1),
        .in2        (in2),
        .busy       (busy),
        .done       (done),
        .out1       (out1),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_SUB_03_SAT_EN
    localparam logic [7:0] UNDERFLOW_OUT = 8'd0;
    localparam logic [7:0] WRAP_0_255    = 8'd0;
`else
    localparam logic [7:0] UNDERFLOW_OUT = 8'hFE;
    localparam logic [7:0] WRAP_0_255    = 8'd1;
`endif

    // One full operation; glitch_k >= 0 pulses start with new operands in that busy cycle
    task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_o, input logic exp_b, input int glitch_k);
        int         busy_cnt;
        int         done_cnt;
        int         done_at;
        logic       stable;
        logic [7:0] prev_out;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        stable   = 1'b1;
        prev_out = out1;
        start = 1'b1;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        in1   = 8'hAA;
        in2   = 8'h55;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k < 8 && out1 !== prev_out) stable = 1'b0;
            if (k == 8) begin
                vectors++;
                if (out1 !== exp_o) begin
                    miscompares++;
                    $display("FAIL %s out1: got %0d expected %0d", nm, out1, exp_o);
                end
                vectors++;
                if (borrow_out !== exp_b) begin
                    miscompares++;
                    $display("FAIL %s borrow_out: got %0b expected %0b", nm, borrow_out, exp_b);
                end
            end
            if (k == glitch_k) begin
                start = 1'b1;
                in1   = 8'd5;
                in2   = 8'd7;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        vectors++;
        if (done_at !== 8) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d expected 8", nm, done_at);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d expected 1", nm, done_cnt);
        end
        vectors++;
        if (busy_cnt !== 9) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected 9", nm, busy_cnt);
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out1_stable_in_shift: got %0b expected 1", nm, stable);
        end
        vectors++;
        if (out1 !== exp_o) begin
            miscompares++;
            $display("FAIL %s out1_hold: got %0d expected %0d", nm, out1, exp_o);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        in1   = 8'd9;
        in2   = 8'd1;
        tick();
        tick();
        start = 1'b0;
        vectors++;
        if ({busy, done, out1, borrow_out} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b done=%0b out1=%0d borrow=%0b expected all 0",
                     busy, done, out1, borrow_out);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %0b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        do_op("basic_200_55", 8'd200, 8'd55, 8'd145, 1'b0, -1);
    endtask

    task automatic test_underflow();
        do_op("underflow_5_7", 8'd5, 8'd7, UNDERFLOW_OUT, 1'b1, -1);
    endtask

    task automatic test_edges();
        do_op("edge_0_0", 8'd0, 8'd0, 8'd0, 1'b0, -1);
        do_op("edge_255_0", 8'd255, 8'd0, 8'd255, 1'b0, -1);
        do_op("edge_0_255", 8'd0, 8'd255, WRAP_0_255, 1'b1, -1);
    endtask

    task automatic test_start_during_busy();
        do_op("start_in_busy", 8'd200, 8'd55, 8'd145, 1'b0, 2);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        start = 1'b1;
        in1   = 8'd200;
        in2   = 8'd55;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out1 !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: got busy=%0b out1=%0d done=%0b expected 0/0/0",
                     busy, out1, done);
        end
        for (int k = 0; k < 12; k++) begin
            if (done) done_cnt++;
            tick();
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d expected 0", done_cnt);
        end
        do_op("after_reset_10_3", 8'd10, 8'd3, 8'd7, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        int done_pos[$];
        int bad_val;
        bad_val = 0;
        start = 1'b1;
        in1   = 8'd100;
        in2   = 8'd1;
        tick();
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                done_pos.push_back(k);
                if (out1 !== 8'd99 || borrow_out !== 1'b0) bad_val++;
            end
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        vectors++;
        if (done_pos.size() !== 3) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d expected 3", done_pos.size());
        end else begin
            vectors++;
            if (done_pos[0] !== 8 || done_pos[1] !== 18 || done_pos[2] !== 28) begin
                miscompares++;
                $display("FAIL b2b_done_spacing: got %0d,%0d,%0d expected 8,18,28",
                         done_pos[0], done_pos[1], done_pos[2]);
            end
        end
        vectors++;
        if (bad_val !== 0) begin
            miscompares++;
            $display("FAIL b2b_result: got %0d bad results expected 0 (out1=99)", bad_val);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in1   = 8'd0;
        in2   = 8'd0;
        test_reset();
        test_basic();
        test_underflow();
        test_edges();
        test_start_during_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
